mul_share_ctrl: RTL and testbench
=================================

Name: mul_share_ctrl

Overview:
- Sequencer/arbiter that shares the single 16-bit combinational tree multiplier (16 partial-product rows, 4-level adder tree) between NUM_REQ requesters, e.g. the CPU execute stage and the address-generation unit.
- Grants requests round-robin and registers the operands onto the multiplier inputs.
- Waits a fixed settle time for the deep adder tree, then captures the truncated 16-bit product and returns it with a one-cycle done pulse to the owner.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- MUL_WAIT, 2, cycles the operands are held on the multiplier before the product is sampled (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held high until granted.
- op_a  input  NUM_REQ x 16  per-requester operand A.
- op_b  input  NUM_REQ x 16  per-requester operand B.
- gnt  output  NUM_REQ  one-hot accept pulse; operands are sampled this cycle.
- done  output  NUM_REQ  one-hot, one-cycle result-valid pulse to the owner.
- result  output  16  product register; holds its value until the next capture.
- busy  output  1  high whenever the state is not IDLE.
- mul_a  output  16  registered operand A to the multiplier.
- mul_b  output  16  registered operand B to the multiplier.
- mul_out  input  16  multiplier product, low 16 bits.

Behaviour:
- Reset (asynchronous, active-high) drives all outputs and state to zero:
  - state=IDLE; mul_a, mul_b, result=0; gnt, done=0; busy=0.
  - rr pointer=0; owner=0; wait counter=0.
- Reset asserted mid-operation drops the in-flight operation: no done is ever issued for it.
- States:
  - IDLE -> WAIT on any req.
  - WAIT -> DONE when the counter reaches MUL_WAIT.
  - DONE -> IDLE unconditionally.
- Grant:
  - gnt is combinational, asserted only in IDLE.
  - Winner is the first set req at or after the rr pointer, wrapping from NUM_REQ-1 to 0.
  - On the grant edge: mul_a/mul_b <= op_a/op_b of the winner; owner <= winner; rr pointer <= (winner+1) mod NUM_REQ; counter <= 1.
- WAIT: counter increments each cycle. When counter==MUL_WAIT, result <= mul_out at that edge.
- DONE: done[owner]=1 for exactly this cycle; no grant is issued in DONE.
- Latency: with gnt in cycle T, done and the valid result appear in cycle T+MUL_WAIT+1. Next grant is possible no earlier than T+MUL_WAIT+2.
- mul_a and mul_b stay stable from T+1 through DONE and keep their values in IDLE; they are not cleared.
- Arithmetic: the product is the low 16 bits of A*B. Overflow is silently truncated and unsigned/two's-complement agnostic.
- Simultaneous requests: only one gnt per grant; losers keep req high and are served in later rounds.
- A requester dropping req before its grant is simply not served.
- req asserted during WAIT/DONE is ignored until IDLE.
- A requester re-requesting in IDLE straight after its own done competes normally; the pointer already points past it.

Optional Feature:
- Macro MUL_FASTPATH_EN.
- When defined: in IDLE, if the winner's op_a or op_b is 0 or 1, the controller skips WAIT.
  - result <= the trivial product (0, or the other operand) at the grant edge.
  - Next state is DONE, so done appears in T+1.
  - mul_a/mul_b are still loaded.
- When undefined: all operations take the full MUL_WAIT path.

Decomposition:
- Package mul_share_pkg holds:
  - WORD_W=16.
  - Typedef word_t.
  - Enum state_t {IDLE, WAIT, DONE}.
  - Constant MAX_REQ=4.
- Sub-module rr_arbiter (inputs: req vector, pointer; outputs: one-hot grant, winner index) is combinational and reusable by the bus controller.

Test Plan:
- Single request: req[0], A=0x0003, B=0x0005, MUL_WAIT=2 -> gnt[0] at T, done[0] at T+3, result=0x000F, busy high for T+1..T+3.
- Contention: req=2'b11 every cycle, requester0 A=2,B=3 and requester1 A=4,B=5 -> grants alternate 0,1,0,...; results 0x0006 and 0x0014 with the matching done bits; no starvation over 10 ops.
- Truncation: A=0x0100, B=0x0100 -> result=0x0000; A=0xFFFF, B=0xFFFF -> result=0x0001.
- Reset mid-WAIT: grant A=7,B=9, assert reset at T+1 -> all outputs 0 immediately (asynchronous), no done pulse, next request served from pointer 0.
- Fastpath: with MUL_FASTPATH_EN, A=0x1234, B=1 -> done at T+1, result=0x1234. Without the macro -> done at T+3.
- Hold/ignore: req[1] rises during WAIT of a requester0 op -> no gnt until IDLE; gnt[1] in the first IDLE cycle, with its operands sampled then.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
// Fastpath helpers are only referenced when MUL_FASTPATH_EN is defined.
package mul_share_pkg;
  localparam int WORD_W  = 16;
  localparam int MAX_REQ = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  function automatic logic is_trivial(word_t a, word_t b);
    return (a <= word_t'(1)) || (b <= word_t'(1));
  endfunction

  // Product when one operand is 0 or 1; no multiplier needed.
  function automatic word_t trivial_prod(word_t a, word_t b);
    if (a == '0 || b == '0) return '0;
    else if (a == word_t'(1)) return b;
    else return a;
  endfunction
endpackage

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set req at or after ptr, wrapping.
// Reusable; carries no state of its own.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);
  // Lowest index below ptr is the fallback; lowest index at/after ptr overrides it.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int j = N-1; j >= 0; j--) begin
      if (req[j] && j < int'(ptr)) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
    for (int j = N-1; j >= 0; j--) begin
      if (req[j] && j >= int'(ptr)) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one combinational 16-bit multiplier among NUM_REQ requesters round-robin.
// Optional MUL_FASTPATH_EN: operands of 0/1 bypass the multiplier settle wait.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int MUL_WAIT = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]  op_a,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]  op_b,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              done,
  output word_t                           result,
  output logic                            busy,
  output word_t                           mul_a,
  output word_t                           mul_b,
  input  word_t                           mul_out
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 4;

  state_t             state;
  logic [IDX_W-1:0]   ptr, owner, win, ptr_nxt;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [CNT_W-1:0]   cnt;
  word_t              win_a, win_b;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (win)
  );

  assign win_a   = op_a[win];
  assign win_b   = op_b[win];
  assign ptr_nxt = (win == IDX_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
  // Gated by reset so nothing is accepted while reset is held.
  assign gnt     = (state == IDLE && !reset) ? arb_gnt : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mul_a  <= '0;
      mul_b  <= '0;
      result <= '0;
      done   <= '0;
      busy   <= 1'b0;
      ptr    <= '0;
      owner  <= '0;
      cnt    <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: if (|arb_gnt) begin
          mul_a <= win_a;
          mul_b <= win_b;
          owner <= win;
          ptr   <= ptr_nxt;
          cnt   <= CNT_W'(1);
          busy  <= 1'b1;
`ifdef MUL_FASTPATH_EN
          if (is_trivial(win_a, win_b)) begin
            result <= trivial_prod(win_a, win_b);
            done   <= NUM_REQ'(1) << win;
            state  <= DONE;
          end else begin
            state  <= WAIT;
          end
`else
          state <= WAIT;
`endif
        end
        WAIT: begin
          // Operands have been stable MUL_WAIT cycles; the adder tree has settled.
          if (cnt == CNT_W'(MUL_WAIT)) begin
            result <= mul_out;
            done   <= NUM_REQ'(1) << owner;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl with a behavioural reference model.
module tb_mul_share_ctrl;
  localparam int N  = 2;
  localparam int MW = 2;
`ifdef MUL_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req;
  logic [N-1:0][15:0]   op_a, op_b;
  logic [N-1:0]         gnt, done;
  logic [15:0]          result, mul_a, mul_b, mul_out;
  logic                 busy;

  int          n_run = 0, n_fail = 0;
  int          exp_ptr = 0;
  logic [15:0] exp_res = '0;

  always #5 clk = ~clk;

  // Behavioural multiplier: low 16 bits of the product.
  assign mul_out = mul_a * mul_b;

  mul_share_ctrl #(.NUM_REQ(N), .MUL_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .done(done), .result(result), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out)
  );

  function automatic int lat(logic [15:0] a, logic [15:0] b);
    if (FAST && (a <= 16'd1 || b <= 16'd1)) return 1;
    return MW + 1;
  endfunction

  function automatic logic [15:0] prod(logic [15:0] a, logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    return p[15:0];
  endfunction

  function automatic int pick(logic [N-1:0] r, int ptr);
    for (int i = 0; i < N; i++)
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(int w);
    logic [N-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] rnd_op();
    if ($urandom_range(0, 5) == 0) return 16'($urandom_range(0, 1));
    return 16'($urandom);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_run++;
    if ({gnt, done, busy, result, mul_a, mul_b} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {gnt, done, busy, result, mul_a, mul_b}); end
    reset = 1'b0;
    exp_ptr = 0; exp_res = '0;
  endtask

  task automatic test_single();
    int L;
    cyc(); op_a[0] = 16'h0003; op_b[0] = 16'h0005; req = 2'b01;
    @(negedge clk);
    n_run++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b want 01", gnt); end
    L = lat(16'h3, 16'h5);
    cyc(); req = '0;
    for (int k = 1; k <= L + 1; k++) begin
      if (k > 1) @(negedge clk); else @(negedge clk);
      n_run++;
      if ({busy, done} !== {(k <= L), (k == L) ? 2'b01 : 2'b00})
        begin n_fail++; $display("FAIL single_busy_done k=%0d: got %b%b want %b%b", k, busy, done, (k <= L), (k == L) ? 2'b01 : 2'b00); end
      if (k == L) begin
        n_run++;
        if (result !== 16'h000F) begin n_fail++; $display("FAIL single_result: got %h want 000f", result); end
      end
    end
    exp_ptr = 1; exp_res = 16'h000F;
  endtask

  task automatic test_truncation();
    logic [15:0] ta [2] = '{16'h0100, 16'hFFFF};
    logic [15:0] tr [2] = '{16'h0000, 16'h0001};
    int L;
    for (int t = 0; t < 2; t++) begin
      cyc(); op_a[1] = ta[t]; op_b[1] = ta[t]; req = 2'b10;
      @(negedge clk);
      n_run++;
      if (gnt !== 2'b10) begin n_fail++; $display("FAIL trunc_gnt %0d: got %b want 10", t, gnt); end
      L = lat(ta[t], ta[t]);
      cyc(); req = '0;
      for (int k = 1; k <= L; k++) @(negedge clk);
      n_run++;
      if ({done, result} !== {2'b10, tr[t]})
        begin n_fail++; $display("FAIL trunc_result %0d: got %b/%h want 10/%h", t, done, result, tr[t]); end
    end
    exp_ptr = 0; exp_res = tr[1];
  endtask

  task automatic test_contention();
    int w, L, cnt0, cnt1;
    logic [15:0] ea, eb;
    cnt0 = 0; cnt1 = 0;
    cyc();
    op_a[0] = 16'd2; op_b[0] = 16'd3; op_a[1] = 16'd4; op_b[1] = 16'd5; req = 2'b11;
    for (int op = 0; op < 10; op++) begin
      @(negedge clk);
      w = pick(2'b11, exp_ptr);
      n_run++;
      if (gnt !== oh(w)) begin n_fail++; $display("FAIL cont_gnt op%0d: got %b want %b", op, gnt, oh(w)); end
      if (w == 0) cnt0++; else cnt1++;
      ea = op_a[w]; eb = op_b[w];
      exp_ptr = (w + 1) % N;
      L = lat(ea, eb);
      for (int k = 1; k <= L; k++) @(negedge clk);
      exp_res = prod(ea, eb);
      n_run++;
      if ({done, result} !== {oh(w), exp_res})
        begin n_fail++; $display("FAIL cont_done op%0d: got %b/%h want %b/%h", op, done, result, oh(w), exp_res); end
    end
    cyc(); req = '0;
    n_run++;
    if (cnt0 != 5 || cnt1 != 5) begin n_fail++; $display("FAIL cont_fairness: got %0d/%0d want 5/5", cnt0, cnt1); end
  endtask

  task automatic test_reset_mid();
    int L;
    bit stray;
    cyc(); op_a[0] = 16'd7; op_b[0] = 16'd9; req = 2'b01;
    @(negedge clk);
    n_run++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL rmid_gnt: got %b want 01", gnt); end
    cyc(); req = '0;
    #2; reset = 1'b1; req = 2'b11;
    #1;
    n_run++;
    if ({gnt, done, busy, result, mul_a, mul_b} !== '0)
      begin n_fail++; $display("FAIL rmid_async_clear: got %h want 0", {gnt, done, busy, result, mul_a, mul_b}); end
    @(posedge clk); @(negedge clk);
    reset = 1'b0; req = '0;
    stray = 1'b0;
    for (int k = 0; k < MW + 3; k++) begin
      @(negedge clk);
      if (done !== '0 || busy !== 1'b0) stray = 1'b1;
    end
    n_run++;
    if (stray) begin n_fail++; $display("FAIL rmid_no_done: got stray done/busy want none"); end
    cyc(); op_a[1] = 16'd3; op_b[1] = 16'd4; req = 2'b11;
    @(negedge clk);
    n_run++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL rmid_ptr_reset: got %b want 01", gnt); end
    L = lat(16'd7, 16'd9);
    cyc(); req = '0;
    for (int k = 1; k <= L; k++) @(negedge clk);
    n_run++;
    if ({done, result} !== {2'b01, 16'd63})
      begin n_fail++; $display("FAIL rmid_result: got %b/%h want 01/003f", done, result); end
    exp_ptr = 1; exp_res = 16'd63;
  endtask

  task automatic test_hold();
    int L, L2;
    bit early;
    cyc(); op_a[0] = 16'h0011; op_b[0] = 16'h0003; req = 2'b01;
    @(negedge clk);
    n_run++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL hold_gnt0: got %b want 01", gnt); end
    L = lat(16'h11, 16'h3);
    cyc(); req = 2'b10; op_a[1] = 16'hAAAA; op_b[1] = 16'h0002;
    early = 1'b0;
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      if (gnt !== '0) early = 1'b1;
    end
    n_run++;
    if (early) begin n_fail++; $display("FAIL hold_no_gnt_busy: got gnt while busy want none"); end
    cyc(); op_a[1] = 16'h0ABC;
    @(negedge clk);
    n_run++;
    if (gnt !== 2'b10) begin n_fail++; $display("FAIL hold_gnt1_idle: got %b want 10", gnt); end
    cyc(); req = '0;
    @(negedge clk);
    n_run++;
    if ({mul_a, mul_b} !== {16'h0ABC, 16'h0002})
      begin n_fail++; $display("FAIL hold_sampled_ops: got %h/%h want 0abc/0002", mul_a, mul_b); end
    L2 = lat(16'h0ABC, 16'h0002);
    for (int k = 2; k <= L2; k++) @(negedge clk);
    n_run++;
    if ({done, result} !== {2'b10, 16'h1578})
      begin n_fail++; $display("FAIL hold_result: got %b/%h want 10/1578", done, result); end
    exp_ptr = 0; exp_res = 16'h1578;
  endtask

  task automatic test_random();
    bit          pend [N];
    logic [15:0] pa [N], pb [N];
    logic [N-1:0] rq, eg, ed;
    logic [15:0] ca, cb;
    int cd, ow, w;
    bit eb;
    cd = 0; ow = 0; ca = '0; cb = '0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        if (c >= 380) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1; pa[i] = rnd_op(); pb[i] = rnd_op();
        end else if (pend[i] && $urandom_range(0, 24) == 0) pend[i] = 1'b0;
        if (!pend[i]) begin pa[i] = 16'($urandom); pb[i] = 16'($urandom); end
        rq[i] = pend[i]; op_a[i] = pa[i]; op_b[i] = pb[i];
      end
      req = rq;
      @(negedge clk);
      if (cd > 0) begin
        cd--;
        eg = '0; eb = 1'b1;
        ed = (cd == 0) ? oh(ow) : '0;
        if (cd == 0) exp_res = prod(ca, cb);
        n_run++;
        if ({mul_a, mul_b} !== {ca, cb})
          begin n_fail++; $display("FAIL rand_mul_ops c=%0d: got %h/%h want %h/%h", c, mul_a, mul_b, ca, cb); end
      end else begin
        eb = 1'b0; ed = '0;
        w = pick(rq, exp_ptr);
        eg = oh(w);
        if (w >= 0) begin
          ow = w; ca = pa[w]; cb = pb[w];
          exp_ptr = (w + 1) % N;
          cd = lat(ca, cb);
          pend[w] = 1'b0;
        end
      end
      n_run++;
      if ({gnt, done, busy, result} !== {eg, ed, eb, exp_res})
        begin n_fail++; $display("FAIL rand_cycle c=%0d: got g%b d%b b%b r%h want g%b d%b b%b r%h", c, gnt, done, busy, result, eg, ed, eb, exp_res); end
    end
    req = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_truncation();
    test_contention();
    test_reset_mid();
    test_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
